// File: rtl/conv_seq_ctrl_if.sv
// Handshake bundle between the frame sequencer, the pixel host, the
// convolution/pooling core and the result consumer.
interface conv_seq_ctrl_if;
   localparam int unsigned DW = 16;

   // host pixel stream
   logic          pix_valid;
   logic          pix_ready;
   logic [DW-1:0] pix_data;

   // core control and data
   logic          core_w_load;
   logic          core_i_load;
   logic [DW-1:0] core_img_in;
   logic [DW-1:0] core_pool_out;
   logic          core_done_pooling;

   // result stream
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;

   // sequencer side
   modport master (
      input  pix_valid, pix_data, core_pool_out, core_done_pooling, res_ready,
      output pix_ready, core_w_load, core_i_load, core_img_in, res_valid, res_data
   );

   // host / core / consumer side
   modport slave (
      output pix_valid, pix_data, core_pool_out, core_done_pooling, res_ready,
      input  pix_ready, core_w_load, core_i_load, core_img_in, res_valid, res_data
   );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer for the convolution/pooling core: weight-load pulse, fixed
// settle wait, pixel streaming, result collection into a small FIFO, drain,
// done pulse. Flags dropped results (FIFO full) and a stalled core (timeout).
module conv_seq_ctrl #(
   parameter int unsigned IMG        = 7,
   parameter int unsigned PAD        = 1,
   parameter int unsigned N_OUT      = 9,
   parameter int unsigned W_LAT      = 3,
   parameter int unsigned TIMEOUT    = 1023,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            err_ovf,
   output logic            err_timeout,
   conv_seq_ctrl_if.master bus
);
   localparam int unsigned DW     = 16;
   localparam int unsigned NPIX   = IMG * IMG;
   localparam int unsigned PIX_W  = $clog2(NPIX + 1);
   localparam int unsigned RES_W  = $clog2(N_OUT + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned WCNT_W = 4;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

   // Padding is owned by the core; a pad wider than the image is not a
   // configuration the core supports, so such an instance elaborates nothing extra.
   if (PAD > IMG) begin : g_pad_exceeds_img
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_WAIT_W, S_LOAD_I, S_RUN, S_DRAIN, S_FIN
   } state_t;

   state_t              state;
   logic [WCNT_W-1:0]   wait_cnt;
   logic [PIX_W-1:0]    pix_cnt;
   logic [RES_W-1:0]    res_cnt;
   logic [TMO_W-1:0]    tmo_cnt;

   logic [DW-1:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    fifo_cnt;

   logic pix_acc_c;
   logic pop_c;
   logic fifo_full_c;
   logic push_req_c;
   logic push_c;

   // Handshake decodes; pix_ready follows state directly so a beat can land in
   // the first LOAD_I cycle.
   assign bus.pix_ready = (state == S_LOAD_I);
   assign pix_acc_c     = bus.pix_valid && (state == S_LOAD_I);
   assign bus.res_valid = (fifo_cnt != '0);
   assign bus.res_data  = mem[rd_ptr];
   assign pop_c         = bus.res_valid && bus.res_ready;
   assign fifo_full_c   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign push_req_c    = (state == S_RUN) && bus.core_done_pooling;
   assign push_c        = push_req_c && (!fifo_full_c || pop_c);

   // Result FIFO: push from the core in RUN, pop whenever the consumer takes the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem      <= '{default: '0};
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_c) begin
            mem[wr_ptr] <= bus.core_pool_out;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_c && !pop_c) begin
            fifo_cnt <= fifo_cnt + CNT_W'(1);
         end else if (pop_c && !push_c) begin
            fifo_cnt <= fifo_cnt - CNT_W'(1);
         end
      end
   end

   // Frame sequencer with registered status and core strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_ovf         <= 1'b0;
         err_timeout     <= 1'b0;
         bus.core_w_load <= 1'b0;
         bus.core_i_load <= 1'b0;
         bus.core_img_in <= '0;
         wait_cnt        <= '0;
         pix_cnt         <= '0;
         res_cnt         <= '0;
         tmo_cnt         <= '0;
      end else begin
         bus.core_w_load <= 1'b0;
         bus.core_i_load <= pix_acc_c;
         done            <= 1'b0;
         if (pix_acc_c) begin
            bus.core_img_in <= bus.pix_data;
         end
         // a result arriving at a full FIFO with no pop in the same cycle is lost
         if (push_req_c && fifo_full_c && !pop_c) begin
            err_ovf <= 1'b1;
         end

         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state           <= S_LOAD_W;
                  busy            <= 1'b1;
                  err_ovf         <= 1'b0;
                  err_timeout     <= 1'b0;
                  bus.core_w_load <= 1'b1;
               end
            end
            S_LOAD_W: begin
               state    <= S_WAIT_W;
               wait_cnt <= '0;
            end
            S_WAIT_W: begin
               if (wait_cnt == WCNT_W'(W_LAT - 1)) begin
                  state   <= S_LOAD_I;
                  pix_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WCNT_W'(1);
               end
            end
            S_LOAD_I: begin
               if (pix_acc_c) begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
                  if (pix_cnt == PIX_W'(NPIX - 1)) begin
                     state   <= S_RUN;
                     res_cnt <= '0;
                     tmo_cnt <= '0;
                  end
               end
            end
            S_RUN: begin
               // dropped results still count toward the frame total
               if (bus.core_done_pooling) begin
                  res_cnt <= res_cnt + RES_W'(1);
                  tmo_cnt <= '0;
                  if (res_cnt == RES_W'(N_OUT - 1)) begin
                     state <= S_DRAIN;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
                  if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                     err_timeout <= 1'b1;
                     state       <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (fifo_cnt == '0) begin
                  state <= S_FIN;
                  done  <= 1'b1;
               end
            end
            S_FIN: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: a cycle-level frame model predicts
// handshakes, flags and the exact pixel/result streams; a negedge monitor
// pops the expected streams whenever the DUT presents a pixel or a result.
module tb_conv_seq_ctrl;
   localparam int unsigned IMG     = 7;
   localparam int unsigned NPIX    = IMG * IMG;
   localparam int unsigned N_OUT   = 9;
   localparam int unsigned W_LAT   = 3;
   localparam int unsigned TIMEOUT = 1023;
   localparam int unsigned DEPTH   = 4;
   localparam int          BUDGET  = 3000;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy, done, err_ovf, err_timeout;

   conv_seq_ctrl_if bus ();

   conv_seq_ctrl #(
      .IMG(IMG), .PAD(1), .N_OUT(N_OUT), .W_LAT(W_LAT),
      .TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .err_ovf(err_ovf), .err_timeout(err_timeout), .bus(bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_pix[$];
   logic [15:0] exp_res[$];
   bit          ovf_exp = 1'b0;
   bit          tmo_exp = 1'b0;
   int          occ = 0;
   logic [15:0] img_model = '0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endfunction

   // Monitor: every pixel strobe and every result pop is matched in order.
   always @(negedge clk) begin
      if (bus.core_i_load === 1'b1) begin
         if (exp_pix.size() == 0) chk("pix_spurious", 32'(bus.core_i_load), 32'd0);
         else chk("pix_data", 32'(bus.core_img_in), 32'(exp_pix.pop_front()));
      end
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
         if (exp_res.size() == 0) chk("res_spurious", 32'(bus.res_valid), 32'd0);
         else chk("res_data", 32'(bus.res_data), 32'(exp_res.pop_front()));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_ovf"}, 32'(err_ovf), 32'd0);
      chk({tag, "_tmo"}, 32'(err_timeout), 32'd0);
      chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 32'd0);
      chk({tag, "_w_load"}, 32'(bus.core_w_load), 32'd0);
      chk({tag, "_i_load"}, 32'(bus.core_i_load), 32'd0);
      chk({tag, "_img_in"}, 32'(bus.core_img_in), 32'd0);
      chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      chk({tag, "_res_data"}, 32'(bus.res_data), 32'd0);
   endtask

   // Idle cycles with noise on the core strobe and host valid, both ignored.
   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_pix_ready", 32'(bus.pix_ready), 32'd0);
         chk("idle_res_valid", 32'(bus.res_valid), 32'd0);
         chk("idle_ovf", 32'(err_ovf), 32'(ovf_exp));
         chk("idle_tmo", 32'(err_timeout), 32'(tmo_exp));
         start                 = 1'b0;
         bus.core_done_pooling = 1'($urandom_range(0, 1));
         bus.core_pool_out     = 16'($urandom);
         bus.pix_valid         = 1'($urandom_range(0, 1));
         bus.pix_data          = 16'($urandom);
         bus.res_ready         = 1'b1;
         tick();
      end
      bus.core_done_pooling = 1'b0;
      bus.pix_valid         = 1'b0;
   endtask

   // One frame. gap: 0 none, 1 alternate, 2 random. rr: 0 ready, 1 stalled
   // during RUN, 2 random, 3 ready only when full. stb: 0 every RUN cycle,
   // 1 random gaps, 2 random gaps plus noise outside RUN and start while busy.
   task automatic run_frame(input int gap, input int rr_mode, input int stb_mode,
                            input int n_strobe, input bit basic, input int rst_at);
      int          acc = 0, nres = 0, nstb = 0, idle = 0, c = 1, occ0;
      bit          running = 0, draining = 0, fin = 0, fin_next, iload_exp = 0;
      bit          ready_exp, acc_now, push, keep, pop, run_end, v, stb, rr;
      bit          frame_over = 0;
      logic [15:0] cur_pix;

      cur_pix               = basic ? 16'd1 : 16'($urandom);
      bus.pix_valid         = 1'b0;
      bus.core_done_pooling = 1'b0;
      bus.res_ready         = 1'b1;
      start                 = 1'b1;
      tick();
      start   = 1'b0;
      ovf_exp = 1'b0;
      tmo_exp = 1'b0;

      while (!frame_over) begin
         if (c > BUDGET) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_budget: no done after %0d cycles", c);
            return;
         end
         ready_exp = (c >= int'(2 + W_LAT)) && (acc < int'(NPIX));
         chk("busy", 32'(busy), 32'd1);
         chk("done", 32'(done), 32'(fin));
         chk("w_load", 32'(bus.core_w_load), 32'(c == 1));
         chk("pix_ready", 32'(bus.pix_ready), 32'(ready_exp));
         chk("i_load", 32'(bus.core_i_load), 32'(iload_exp));
         if (!iload_exp) chk("img_hold", 32'(bus.core_img_in), 32'(img_model));
         chk("res_valid", 32'(bus.res_valid), 32'(occ > 0));
         chk("err_ovf", 32'(err_ovf), 32'(ovf_exp));
         chk("err_timeout", 32'(err_timeout), 32'(tmo_exp));

         if (rst_at > 0 && acc == rst_at) begin
            rst                   = 1'b1;
            bus.pix_valid         = 1'b0;
            bus.core_done_pooling = 1'b0;
            tick();
            rst = 1'b0;
            check_zero("abort");
            chk("abort_pix_queue", 32'(exp_pix.size()), 32'd0);
            img_model = '0;
            occ       = 0;
            ovf_exp   = 1'b0;
            tmo_exp   = 1'b0;
            exp_res.delete();
            return;
         end

         // stimulus for this cycle
         case (gap)
            0:       v = 1'b1;
            1:       v = ((c % 2) == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         bus.pix_valid = (acc < int'(NPIX)) && v;
         bus.pix_data  = bus.pix_valid ? cur_pix : 16'($urandom);

         stb = 1'b0;
         if (running && nstb < n_strobe) stb = (stb_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
         else if (!running && stb_mode == 2) stb = ($urandom_range(0, 3) == 0);
         bus.core_done_pooling = stb;
         bus.core_pool_out     = basic ? 16'(100 + nstb) : 16'($urandom);

         case (rr_mode)
            0:       rr = 1'b1;
            1:       rr = !running;
            3:       rr = running ? (occ == int'(DEPTH)) : 1'b1;
            default: rr = 1'($urandom_range(0, 1));
         endcase
         bus.res_ready = rr;
         start = (stb_mode == 2) && ($urandom_range(0, 7) == 0);

         // reference model of the coming edge
         acc_now = bus.pix_valid && ready_exp;
         if (acc_now) begin
            exp_pix.push_back(cur_pix);
            img_model = cur_pix;
            acc++;
            cur_pix = basic ? cur_pix + 16'd1 : 16'($urandom);
         end
         iload_exp = acc_now;

         pop  = (occ > 0) && rr;
         push = running && stb;
         keep = push && (occ < int'(DEPTH) || pop);
         if (push && !keep) ovf_exp = 1'b1;
         if (keep) exp_res.push_back(bus.core_pool_out);
         occ0 = occ;
         occ  = occ - int'(pop) + int'(keep);

         fin_next = draining && (occ0 == 0);
         run_end  = 1'b0;
         if (running) begin
            if (stb) begin
               nstb++;
               nres++;
               idle = 0;
               if (nres == int'(N_OUT)) run_end = 1'b1;
            end else begin
               idle++;
               if (idle == int'(TIMEOUT)) begin
                  run_end = 1'b1;
                  tmo_exp = 1'b1;
               end
            end
         end
         frame_over = fin;
         draining   = (draining && occ0 != 0) || run_end;
         running    = (running && !run_end) || (acc_now && acc == int'(NPIX));
         fin        = fin_next;
         c++;
         tick();
      end
      start = 1'b0;
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_done", 32'(done), 32'd0);
      chk("post_pix_queue", 32'(exp_pix.size()), 32'd0);
      chk("post_res_queue", 32'(exp_res.size()), 32'd0);
   endtask

   initial begin
      rst                   = 1'b1;
      start                 = 1'b0;
      bus.pix_valid         = 1'b0;
      bus.pix_data          = '0;
      bus.core_pool_out     = '0;
      bus.core_done_pooling = 1'b0;
      bus.res_ready         = 1'b0;
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;

      drive_idle(3);
      run_frame(0, 0, 0, N_OUT, 1'b1, 0);   // basic: pixels 1..49, results 100..108
      drive_idle(4);
      run_frame(1, 0, 1, N_OUT, 1'b0, 0);   // host gaps every other cycle
      drive_idle(2);
      run_frame(2, 1, 0, N_OUT, 1'b0, 0);   // consumer stalled: overflow
      drive_idle(2);
      run_frame(0, 3, 0, N_OUT, 1'b0, 0);   // full FIFO with simultaneous pop
      drive_idle(2);
      run_frame(0, 2, 0, 3, 1'b0, 0);       // core stalls after 3 results
      drive_idle(3);
      run_frame(0, 0, 0, N_OUT, 1'b0, 20);  // reset mid pixel load
      drive_idle(3);
      run_frame(0, 0, 0, N_OUT, 1'b1, 0);   // clean frame after abort
      for (int i = 0; i < 6; i++) begin
         drive_idle(int'($urandom_range(1, 4)));
         run_frame(2, 2, 2, N_OUT, 1'b0, 0);
      end
      drive_idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Frame sequencer for the convolution/pooling core.
- On start it pulses the core's weight load, then waits a fixed latency.
- It then streams IMG*IMG pixels from a host valid/ready stream into the core's image load port.
- It collects N_OUT pooled results into a small output FIFO, drains them to a result valid/ready stream, then signals done; it also detects result overflow and a stalled core (timeout).

Parameters:
- IMG, 7, unpadded image side; NPIX = IMG*IMG pixels per frame.
- PAD, 1, padding; informational only, carried so the instance matches the core's configuration.
- N_OUT, 9, pooled results expected per frame.
- W_LAT, 3, idle cycles after the weight-load pulse before the first pixel (1..15).
- TIMEOUT, 1023, maximum cycles in RUN without a core result strobe.
- FIFO_DEPTH, 4, result FIFO entries (power of 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.
- err_ovf  out  1  sticky; a result was dropped because the FIFO was full.
- err_timeout  out  1  sticky; the core stalled in RUN.
- pix_valid  in  1  host pixel valid.
- pix_ready  out  1  controller accepts a pixel.
- pix_data  in  16  signed pixel.
- core_w_load  out  1  one-cycle weight-load pulse to the core.
- core_i_load  out  1  per-pixel load strobe to the core.
- core_img_in  out  16  pixel to the core; valid when core_i_load=1.
- core_pool_out  in  16  pooled result from the core.
- core_done_pooling  in  1  result strobe; core_pool_out is valid in the same cycle.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  downstream accepts a result.
- res_data  out  16  FIFO head entry.

Behaviour:
- Reset:
  - All outputs are 0.
  - State goes to IDLE, FIFO empties, all counters and error flags clear.
  - Reset asserted mid-frame aborts the frame on the next edge; no done pulse is issued.
- States: IDLE, LOAD_W, WAIT_W, LOAD_I, RUN, DRAIN, FIN.
- IDLE:
  - start=1 → LOAD_W. The error flags clear at that edge.
  - core_done_pooling is ignored.
- LOAD_W:
  - Lasts exactly one cycle with core_w_load=1 (registered output, so it is high in the first cycle after start is sampled).
  - Then → WAIT_W.
- WAIT_W:
  - Lasts exactly W_LAT cycles, then → LOAD_I.
- LOAD_I:
  - pix_ready=1, driven combinationally from state.
  - A beat is accepted when pix_valid and pix_ready are both 1 in cycle k.
  - For each accepted beat: core_i_load=1 and core_img_in=pix_data in cycle k+1; otherwise core_i_load=0 and core_img_in holds its last value.
  - Host gaps are allowed; the pixel counter advances only on accepted beats.
  - The accepted beat that brings the count to NPIX moves the state to RUN at the next edge, and pix_ready drops in that same next cycle.
- RUN:
  - Each core_done_pooling=1 pushes core_pool_out into the FIFO and increments the result counter.
  - Push while full: accepted if a pop (res_valid and res_ready) occurs in the same cycle; otherwise the result is dropped, err_ovf is set, and the result counter still increments.
  - The timeout counter clears on every strobe and otherwise increments.
  - The result counter reaching N_OUT → DRAIN.
  - The timeout counter reaching TIMEOUT → set err_timeout, → DRAIN; the remaining results are abandoned.
- DRAIN:
  - Core strobes are ignored.
  - Stays until the FIFO is empty, then → FIN.
- FIN:
  - One cycle with done=1, then → IDLE.
- FIFO:
  - res_data is the registered head entry; res_valid = not empty.
  - A pop happens on res_valid and res_ready, in any state.
  - Simultaneous push and pop keeps occupancy unchanged.
  - A pop when empty has no effect.
- start while busy is ignored.
- Frame latency with no stalls: start → first pixel ready is 2+W_LAT cycles.

Test Plan:
- Basic frame: W_LAT=3, pixels 1..49 sent gap-free, core strobes 9 results 100..108, res_ready=1 → core_w_load in cycle 1, first core_i_load in cycle 6 carrying 1, res_data sequence 100..108, one done pulse, no errors.
- Host gaps: pix_valid toggled every other cycle → exactly 49 core_i_load strobes, pixel order preserved, no duplicates.
- Overflow: res_ready=0 throughout and 6 core strobes → 4 results stored, err_ovf=1 after the 5th strobe; raise res_ready → 4 results drain, done pulses.
- Full with simultaneous pop: FIFO full, push and pop in the same cycle → no drop, err_ovf stays 0.
- Timeout: only 3 core strobes, then silence, TIMEOUT=1023 → err_timeout=1 exactly 1023 cycles after the last strobe, 3 results drain, done pulses; the next start clears the error flags.
- Reset during LOAD_I after 20 pixels → all outputs 0 next cycle, no done pulse; a new start runs a full clean frame.
